unsigned_arith_unit: RTL and testbench

Parametrised, multicycle successor to the combinational unsigned arithmetic block in the ALU arithmetic path. Performs unsigned add, subtract, multiply and divide on WIDTH-bit operands. Uses a start/busy/done handshake, with iterative shift-add multiply and restoring divide. Sits between the ALU opcode decoder and the ALU result mux; the signed unit wraps it.

---
 rtl/unsigned_arith_pkg.sv | 15 +
 rtl/udiv_seq_core.sv | 62 ++++++
 rtl/unsigned_arith_unit.sv | 200 ++++++++++++++++++++
 tb/tb_unsigned_arith_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/unsigned_arith_pkg.sv
// Shared opcode and FSM state definitions for the unsigned arithmetic unit.
package unsigned_arith_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10
  } uarith_state_t;

endpackage

// File: rtl/udiv_seq_core.sv
// Restoring-divide datapath: one quotient bit per enabled cycle.
// The next-state remainder/quotient are exported so the caller can capture the final step.
module udiv_seq_core
  import unsigned_arith_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q_next,
  output logic [WIDTH-1:0] r_next
);

  logic [WIDTH-1:0] rem_r, rem_s;
  logic [WIDTH-1:0] quo_r, quo_s;
  logic [WIDTH-1:0] dsr_r;
  logic [WIDTH:0]   shift_s;
  logic [WIDTH:0]   diff_s;
  logic             fits_s;

  // One restoring step; shift_s is the WIDTH+1-bit partial remainder, and
  // since it is below 2*divisor the top bit of diff_s is a valid sign bit.
  always_comb begin
    shift_s = {rem_r, quo_r[WIDTH-1]};
    diff_s  = shift_s - {1'b0, dsr_r};
    fits_s  = ~diff_s[WIDTH];
    if (fits_s) begin
      rem_s = diff_s[WIDTH-1:0];
    end else begin
      rem_s = shift_s[WIDTH-1:0];
    end
    quo_s = {quo_r[WIDTH-2:0], fits_s};
  end

  assign q_next = quo_s;
  assign r_next = rem_s;

  // Remainder, quotient and divisor registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r <= {WIDTH{1'b0}};
      quo_r <= {WIDTH{1'b0}};
      dsr_r <= {WIDTH{1'b0}};
    end else if (load) begin
      rem_r <= {WIDTH{1'b0}};
      quo_r <= dividend;
      dsr_r <= divisor;
    end else if (en) begin
      rem_r <= rem_s;
      quo_r <= quo_s;
    end else begin
      rem_r <= rem_r;
      quo_r <= quo_r;
      dsr_r <= dsr_r;
    end
  end

endmodule

// File: rtl/unsigned_arith_unit.sv
// Multicycle unsigned add/sub/mul/div with start/busy/done handshake.
// Optional UARITH_DIV0_FAST_EN: divide by zero completes from IDLE in one cycle.
module unsigned_arith_unit
  import unsigned_arith_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] answer_one,
  output logic [WIDTH-1:0] answer_two,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  uarith_state_t    state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] opa_r, opa_s;
  logic [WIDTH-1:0] hi_r, hi_s;
  logic [WIDTH-1:0] lo_r, lo_s;
  logic [WIDTH-1:0] ans1_r, ans1_s;
  logic [WIDTH-1:0] ans2_r, ans2_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             div0_r, div0_s;
  logic             dz_pend_r, dz_pend_s;
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   mul_sum_s;
  logic             div_load_s, div_en_s;
  logic [WIDTH-1:0] div_q_nx_s, div_r_nx_s;

  udiv_seq_core #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (div_load_s),
    .en       (div_en_s),
    .dividend (a),
    .divisor  (b),
    .q_next   (div_q_nx_s),
    .r_next   (div_r_nx_s)
  );

  // Arithmetic for the single-cycle ops and one shift-add multiply step.
  always_comb begin
    add_s = {1'b0, a} + {1'b0, b};
    if (lo_r[0]) begin
      mul_sum_s = {1'b0, hi_r} + {1'b0, opa_r};
    end else begin
      mul_sum_s = {1'b0, hi_r};
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    opa_s      = opa_r;
    hi_s       = hi_r;
    lo_s       = lo_r;
    ans1_s     = ans1_r;
    ans2_s     = ans2_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    div0_s     = div0_r;
    dz_pend_s  = dz_pend_r;
    div_load_s = 1'b0;
    div_en_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          div0_s = 1'b0;
          case (opcode)
            OP_ADD: begin
              ans1_s = add_s[WIDTH-1:0];
              ans2_s = {{(WIDTH-1){1'b0}}, add_s[WIDTH]};
              done_s = 1'b1;
            end
            OP_SUB: begin
              ans1_s = a - b;
              ans2_s = {{(WIDTH-1){1'b0}}, (a < b)};
              done_s = 1'b1;
            end
            OP_MUL: begin
              state_s = MUL;
              cnt_s   = CNT_LOAD;
              opa_s   = a;
              hi_s    = {WIDTH{1'b0}};
              lo_s    = b;
              busy_s  = 1'b1;
            end
            OP_DIV: begin
`ifdef UARITH_DIV0_FAST_EN
              if (b == {WIDTH{1'b0}}) begin
                ans1_s = {WIDTH{1'b1}};
                ans2_s = a;
                div0_s = 1'b1;
                done_s = 1'b1;
              end else begin
                state_s    = DIV;
                cnt_s      = CNT_LOAD;
                busy_s     = 1'b1;
                div_load_s = 1'b1;
                dz_pend_s  = 1'b0;
              end
`else
              state_s    = DIV;
              cnt_s      = CNT_LOAD;
              busy_s     = 1'b1;
              div_load_s = 1'b1;
              dz_pend_s  = (b == {WIDTH{1'b0}});
`endif
            end
            default: begin
              state_s = IDLE;
            end
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      MUL: begin
        hi_s  = mul_sum_s[WIDTH:1];
        lo_s  = {mul_sum_s[0], lo_r[WIDTH-1:1]};
        cnt_s = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          ans1_s  = {mul_sum_s[0], lo_r[WIDTH-1:1]};
          ans2_s  = mul_sum_s[WIDTH:1];
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = IDLE;
        end else begin
          state_s = MUL;
        end
      end
      DIV: begin
        div_en_s = 1'b1;
        cnt_s    = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          ans1_s  = div_q_nx_s;
          ans2_s  = div_r_nx_s;
          div0_s  = dz_pend_r;
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = IDLE;
        end else begin
          state_s = DIV;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      opa_r     <= {WIDTH{1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      ans1_r    <= {WIDTH{1'b0}};
      ans2_r    <= {WIDTH{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      div0_r    <= 1'b0;
      dz_pend_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      opa_r     <= opa_s;
      hi_r      <= hi_s;
      lo_r      <= lo_s;
      ans1_r    <= ans1_s;
      ans2_r    <= ans2_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      div0_r    <= div0_s;
      dz_pend_r <= dz_pend_s;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign answer_one  = ans1_r;
  assign answer_two  = ans2_r;
  assign div_by_zero = div0_r;

endmodule

// File: tb/tb_unsigned_arith_unit.sv
// Scoreboard bench for unsigned_arith_unit (WIDTH=32); honours UARITH_DIV0_FAST_EN.
module tb_unsigned_arith_unit;

  localparam int W = 32;

  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        dz;
    int          lat;
    int          t0;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    opcode = 2'b00;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  answer_one, answer_two;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];

`ifdef UARITH_DIV0_FAST_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = W + 1;
`endif

  unsigned_arith_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .opcode      (opcode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .answer_one  (answer_one),
    .answer_two  (answer_two),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called just after a negedge: presents one request for one cycle.
  task automatic send(input string nm, input logic [1:0] op, input logic [31:0] av,
                      input logic [31:0] bv, input bit accept, input logic [31:0] e1,
                      input logic [31:0] e2, input logic dz, input int lat);
    exp_t e;
    start  = 1'b1;
    opcode = op;
    a      = av;
    b      = bv;
    if (accept) begin
      e.name = nm; e.e1 = e1; e.e2 = e2; e.dz = dz; e.lat = lat; e.t0 = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses outstanding after %0d cycles, expected 0", sb.size(), budget);
      sb.delete();
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no response", cyc);
        end else begin
          e = sb.pop_front();
          check({e.name, ".answer_one"}, 64'(answer_one), 64'(e.e1));
          check({e.name, ".answer_two"}, 64'(answer_two), 64'(e.e2));
          check({e.name, ".div_by_zero"}, 64'(div_by_zero), 64'(e.dz));
          check({e.name, ".latency"}, 64'(cyc - e.t0), 64'(e.lat));
          check({e.name, ".busy_at_done"}, 64'(busy), 64'd0);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.answer_one", 64'(answer_one), 64'd0);
    check("reset.answer_two", 64'(answer_two), 64'd0);
    check("reset.div_by_zero", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send("add_carry", 2'b00, 32'hFFFF_FFFF, 32'h2, 1'b1, 32'h1, 32'h1, 1'b0, 1);
    send("add_plain", 2'b00, 32'h2, 32'h3, 1'b1, 32'h5, 32'h0, 1'b0, 1);
    send("sub_borrow", 2'b10, 32'h3, 32'h5, 1'b1, 32'hFFFF_FFFE, 32'h1, 1'b0, 1);
    send("sub_plain", 2'b10, 32'hA, 32'h3, 1'b1, 32'h7, 32'h0, 1'b0, 1);
    wait_drain(10);

    // Maximal multiply; a start while busy must be ignored.
    send("mul_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h1, 32'hFFFF_FFFE, 1'b0, W + 1);
    repeat (3) @(negedge clk);
    check("mul_max.busy_mid", 64'(busy), 64'd1);
    send("ignored", 2'b00, 32'h5, 32'h5, 1'b0, 32'h0, 32'h0, 1'b0, 0);
    wait_drain(60);

    send("mul_hi", 2'b11, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0, 32'h1, 1'b0, W + 1);
    wait_drain(60);

    // Divide, then an add issued in the divide's done cycle.
    send("div_100_7", 2'b01, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, W + 1);
    repeat (W) @(negedge clk);
    send("add_b2b", 2'b00, 32'h1, 32'h1, 1'b1, 32'h2, 32'h0, 1'b0, 1);
    wait_drain(10);

    send("div_by_one", 2'b01, 32'hDEAD_BEEF, 32'h1, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, W + 1);
    wait_drain(60);

    send("div_zero", 2'b01, 32'h1234, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h1234, 1'b1, DIV0_LAT);
    wait_drain(60);
    send("dz_clear", 2'b00, 32'h10, 32'h20, 1'b1, 32'h30, 32'h0, 1'b0, 1);
    wait_drain(10);

    // Reset in the middle of a multiply aborts it without a done.
    send("mul_abort", 2'b11, 32'd7, 32'd9, 1'b0, 32'h0, 32'h0, 1'b0, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.done", 64'(done), 64'd0);
    check("abort.answer_one", 64'(answer_one), 64'd0);
    check("abort.answer_two", 64'(answer_two), 64'd0);
    check("abort.div_by_zero", 64'(div_by_zero), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 5) @(negedge clk);
    send("mul_fresh", 2'b11, 32'd7, 32'd9, 1'b1, 32'd63, 32'd0, 1'b0, W + 1);
    wait_drain(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
